// File: rtl/reg_file_mp_pkg.sv
// ============================================================================
// Module      : reg_file_mp_pkg
// Description : Shared defaults and index helper for the multi-port reg file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_mp_pkg;

    localparam int DW_DEF     = 8;
    localparam int AW_DEF     = 4;
    localparam int LR_IDX_DEF = 14;

    // Top index of the address space aliases the PC and has no storage.
    function automatic int pc_idx(input int aw);
        return (2 ** aw) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_mp_if.sv
// ============================================================================
// Module      : reg_file_mp_if
// Description : Write, link-write, read and debug signals of the reg file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_mp_if
    import reg_file_mp_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);

    logic          WEN;
    logic [AW-1:0] Add2;
    logic [DW-1:0] wdata;
    logic          LEN;
    logic [DW-1:0] ldata;
    logic [AW-1:0] Add0;
    logic [AW-1:0] Add1;
    logic [DW-1:0] PC8;
    logic [DW-1:0] Out0;
    logic [DW-1:0] Out1;
    logic [AW-1:0] DbgAdd;
    logic [DW-1:0] DbgOut;

    modport master (
        output WEN, Add2, wdata, LEN, ldata, Add0, Add1, PC8, DbgAdd,
        input  Out0, Out1, DbgOut
    );

    modport slave (
        input  WEN, Add2, wdata, LEN, ldata, Add0, Add1, PC8, DbgAdd,
        output Out0, Out1, DbgOut
    );

endinterface

`default_nettype wire

// File: rtl/reg_file_mp_rf_bypass_mux.sv
// ============================================================================
// Module      : rf_bypass_mux
// Description : Per-read-port PC alias select and optional write forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_bypass_mux
    import reg_file_mp_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int LR_IDX = LR_IDX_DEF,
    parameter int BYPASS = 0
)(
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [DW-1:0] i_stor,
    input  wire logic [DW-1:0] i_pc8,
    input  wire logic          i_wen,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [DW-1:0] i_wdata,
    input  wire logic          i_len,
    input  wire logic [DW-1:0] i_ldata,
    output logic      [DW-1:0] o_dout
);

    localparam logic [AW-1:0] c_PC_IDX = AW'(pc_idx(AW));
    localparam logic [AW-1:0] c_LR_IDX = AW'(LR_IDX);

    logic w_hit_main;
    logic w_hit_link;

    assign w_hit_main = i_wen && (i_waddr == i_addr);
    assign w_hit_link = i_len && (i_addr == c_LR_IDX);

    // Main-port hit is tested first so it wins over the link port on LR_IDX.
    always_comb begin
        o_dout = i_stor;
        if (i_addr == c_PC_IDX) begin
            o_dout = i_pc8;
        end else if ((BYPASS != 0) && w_hit_main) begin
            o_dout = i_wdata;
        end else if ((BYPASS != 0) && w_hit_link) begin
            o_dout = i_ldata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module      : reg_file_mp
// Description : Two-read, main+link-write register file with PC alias.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int LR_IDX = LR_IDX_DEF,
    parameter int BYPASS = 0
)(
    input  wire logic   CLK,
    input  wire logic   RST,
    reg_file_mp_if.slave bus
);

    localparam int            c_NREG   = 2 ** AW;
    localparam logic [AW-1:0] c_PC_IDX = AW'(pc_idx(AW));
    localparam logic [AW-1:0] c_LR_IDX = AW'(LR_IDX);

    logic [DW-1:0] r_regs [c_NREG-1];

    // Link write first so a main write to the same index overrides it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < c_NREG - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (bus.LEN) begin
                r_regs[c_LR_IDX] <= bus.ldata;
            end
            if (bus.WEN && (bus.Add2 != c_PC_IDX)) begin
                r_regs[bus.Add2] <= bus.wdata;
            end
        end
    end

    logic [DW-1:0] w_stor0;
    logic [DW-1:0] w_stor1;
    logic [DW-1:0] w_stor_dbg;

    assign w_stor0    = (bus.Add0   == c_PC_IDX) ? '0 : r_regs[bus.Add0];
    assign w_stor1    = (bus.Add1   == c_PC_IDX) ? '0 : r_regs[bus.Add1];
    assign w_stor_dbg = (bus.DbgAdd == c_PC_IDX) ? '0 : r_regs[bus.DbgAdd];

    assign bus.DbgOut = (bus.DbgAdd == c_PC_IDX) ? bus.PC8 : w_stor_dbg;

    rf_bypass_mux #(
        .DW     (DW),
        .AW     (AW),
        .LR_IDX (LR_IDX),
        .BYPASS (BYPASS)
    ) u_port0 (
        .i_addr  (bus.Add0),
        .i_stor  (w_stor0),
        .i_pc8   (bus.PC8),
        .i_wen   (bus.WEN),
        .i_waddr (bus.Add2),
        .i_wdata (bus.wdata),
        .i_len   (bus.LEN),
        .i_ldata (bus.ldata),
        .o_dout  (bus.Out0)
    );

    rf_bypass_mux #(
        .DW     (DW),
        .AW     (AW),
        .LR_IDX (LR_IDX),
        .BYPASS (BYPASS)
    ) u_port1 (
        .i_addr  (bus.Add1),
        .i_stor  (w_stor1),
        .i_pc8   (bus.PC8),
        .i_wen   (bus.WEN),
        .i_waddr (bus.Add2),
        .i_wdata (bus.wdata),
        .i_len   (bus.LEN),
        .i_ldata (bus.ldata),
        .o_dout  (bus.Out1)
    );

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Directed vector table plus random traffic, BYPASS=0 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

    logic       CLK;
    logic       rst;
    logic       wen;
    logic [3:0] add2;
    logic [7:0] wdata;
    logic       len;
    logic [7:0] ldata;
    logic [3:0] add0;
    logic [3:0] add1;
    logic [3:0] dadd;
    logic [7:0] pc8;

    int errors;
    int checks;

    logic [7:0] ref_mem [15];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    reg_file_mp_if #(.DW(8), .AW(4)) bus_nb ();
    reg_file_mp_if #(.DW(8), .AW(4)) bus_b  ();

    assign bus_nb.WEN = wen;    assign bus_b.WEN = wen;
    assign bus_nb.Add2 = add2;  assign bus_b.Add2 = add2;
    assign bus_nb.wdata = wdata; assign bus_b.wdata = wdata;
    assign bus_nb.LEN = len;    assign bus_b.LEN = len;
    assign bus_nb.ldata = ldata; assign bus_b.ldata = ldata;
    assign bus_nb.Add0 = add0;  assign bus_b.Add0 = add0;
    assign bus_nb.Add1 = add1;  assign bus_b.Add1 = add1;
    assign bus_nb.PC8 = pc8;    assign bus_b.PC8 = pc8;
    assign bus_nb.DbgAdd = dadd; assign bus_b.DbgAdd = dadd;

    reg_file_mp #(.DW(8), .AW(4), .LR_IDX(14), .BYPASS(0)) u_dut_nb (
        .CLK (CLK),
        .RST (rst),
        .bus (bus_nb)
    );

    reg_file_mp #(.DW(8), .AW(4), .LR_IDX(14), .BYPASS(1)) u_dut_b (
        .CLK (CLK),
        .RST (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic       rst, wen, len, chk, chkb;
        logic [3:0] add2, add0, add1, dadd;
        logic [7:0] wdata, ldata, pc8;
        logic [7:0] e0, e0b, e1, e1b, ed;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Reference read: PC alias, then forwarding (main over link), then storage.
    function automatic logic [7:0] mdl(input logic [3:0] a, input bit byp);
        if (a == 4'd15) return pc8;
        if (byp && wen && (add2 == a)) return wdata;
        if (byp && len && (a == 4'd14)) return ldata;
        return ref_mem[a];
    endfunction

    task automatic model_commit();
        if (rst) begin
            for (int i = 0; i < 15; i++) ref_mem[i] = 8'h00;
        end else begin
            if (len) ref_mem[14] = ldata;
            if (wen && add2 != 4'd15) ref_mem[add2] = wdata;
        end
    endtask

    task automatic add_vec(input logic r, input logic we, input logic [3:0] a2, input logic [7:0] wd,
                           input logic le, input logic [7:0] ld, input logic [3:0] a0,
                           input logic [3:0] a1, input logic [3:0] da, input logic [7:0] pc,
                           input logic ck, input logic ckb, input logic [7:0] x0, input logic [7:0] x0b,
                           input logic [7:0] x1, input logic [7:0] x1b, input logic [7:0] xd);
        vec_t v;
        v.rst = r; v.wen = we; v.add2 = a2; v.wdata = wd; v.len = le; v.ldata = ld;
        v.add0 = a0; v.add1 = a1; v.dadd = da; v.pc8 = pc; v.chk = ck; v.chkb = ckb;
        v.e0 = x0; v.e0b = x0b; v.e1 = x1; v.e1b = x1b; v.ed = xd;
        vecs.push_back(v);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; wen = 1'b0; add2 = '0; wdata = '0; len = 1'b0; ldata = '0;
        add0 = '0; add1 = '0; dadd = '0; pc8 = 8'h20;
        for (int i = 0; i < 15; i++) ref_mem[i] = 8'hxx;

        // Single-cycle reset pulse, outputs undefined before it.
        add_vec(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h20, 0, 0, 0, 0, 0, 0, 0);
        // Post-reset sweep of every index.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] x;
            x = (i == 15) ? 8'h20 : 8'h00;
            add_vec(0, 0, 0, 8'h00, 0, 8'h00, 4'(i), 4'(15 - i), 4'(i), 8'h20, 1, 1,
                    x, x, (i == 0) ? 8'h20 : 8'h00, (i == 0) ? 8'h20 : 8'h00, x);
        end
        // Write 3 then read it back; forwarding visible only with BYPASS=1.
        add_vec(0, 1, 3, 8'hA5, 0, 8'h00, 3, 3, 3, 8'h20, 1, 1, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 3, 3, 3, 8'h20, 1, 1, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
        // Main and link both on LR: main wins.
        add_vec(0, 1, 14, 8'h11, 1, 8'h22, 14, 14, 14, 8'h20, 1, 1, 8'h00, 8'h11, 8'h00, 8'h11, 8'h00);
        // Main to 5, link to 14 concurrently.
        add_vec(0, 1, 5, 8'h11, 1, 8'h22, 14, 5, 14, 8'h20, 1, 1, 8'h11, 8'h22, 8'h00, 8'h11, 8'h11);
        // Write to PC index is dropped; Add1=15 returns PC8.
        add_vec(0, 1, 15, 8'hFF, 0, 8'h00, 5, 15, 14, 8'h20, 1, 1, 8'h11, 8'h11, 8'h20, 8'h20, 8'h22);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 3, 14, 5, 8'h3C, 1, 1, 8'hA5, 8'hA5, 8'h22, 8'h22, 8'h11);
        // Reset overrides a same-cycle write.
        add_vec(1, 1, 2, 8'h77, 0, 8'h00, 2, 2, 2, 8'h20, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        // Write right after reset release commits.
        add_vec(0, 1, 2, 8'h33, 0, 8'h00, 3, 2, 2, 8'h20, 1, 1, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 2, 14, 3, 8'h20, 1, 1, 8'h33, 8'h33, 8'h00, 8'h00, 8'h00);

        @(posedge CLK);
        #1;
        foreach (vecs[k]) begin
            rst = vecs[k].rst; wen = vecs[k].wen; add2 = vecs[k].add2; wdata = vecs[k].wdata;
            len = vecs[k].len; ldata = vecs[k].ldata; add0 = vecs[k].add0; add1 = vecs[k].add1;
            dadd = vecs[k].dadd; pc8 = vecs[k].pc8;
            @(negedge CLK);
            if (vecs[k].chk) begin
                check($sformatf("vec%0d out0", k), bus_nb.Out0, vecs[k].e0);
                check($sformatf("vec%0d out1", k), bus_nb.Out1, vecs[k].e1);
                check($sformatf("vec%0d dbg", k), bus_nb.DbgOut, vecs[k].ed);
                check($sformatf("vec%0d dbg_b", k), bus_b.DbgOut, vecs[k].ed);
            end
            if (vecs[k].chkb) begin
                check($sformatf("vec%0d out0_b", k), bus_b.Out0, vecs[k].e0b);
                check($sformatf("vec%0d out1_b", k), bus_b.Out1, vecs[k].e1b);
            end
            @(posedge CLK);
            model_commit();
            #1;
        end

        for (int n = 0; n < 1000; n++) begin
            rst = 1'b0;
            wen = 1'($urandom_range(0, 1));
            len = 1'($urandom_range(0, 1));
            add2 = 4'($urandom_range(0, 15));
            add0 = 4'($urandom_range(0, 15));
            add1 = 4'($urandom_range(0, 15));
            dadd = 4'($urandom_range(0, 15));
            wdata = 8'($urandom_range(0, 255));
            ldata = 8'($urandom_range(0, 255));
            pc8 = 8'($urandom_range(0, 255));
            @(negedge CLK);
            check("rnd out0", bus_nb.Out0, mdl(add0, 0));
            check("rnd out1", bus_nb.Out1, mdl(add1, 0));
            check("rnd dbg", bus_nb.DbgOut, mdl(dadd, 0));
            check("rnd out0_b", bus_b.Out0, mdl(add0, 1));
            check("rnd out1_b", bus_b.Out1, mdl(add1, 1));
            check("rnd dbg_b", bus_b.DbgOut, mdl(dadd, 0));
            @(posedge CLK);
            model_commit();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
